// File: rtl/npc_mem_pkg.sv
// Shared definitions for the NPC memory-side bus responder: response codes,
// read/write FSM state types and the delay LFSR seed.
package npc_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [7:0] LFSR_SEED   = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

endpackage

// File: rtl/delay_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that supplies random per-transaction
// wait counts to sram_resp.
import npc_mem_pkg::*;

module delay_lfsr #(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] lfsr_reg;
  logic       feedback;

  assign feedback = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  assign q        = lfsr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= SEED;
    end else if (en) begin
      lfsr_reg <= {lfsr_reg[6:0], feedback};
    end
  end

endmodule

// File: rtl/sram_resp.sv
// Memory-side AXI4-Lite-style responder with independent read/write FSMs and a
// byte-lane word array. Define SRAM_RESP_RAND_DELAY_EN for LFSR-driven delays.
import npc_mem_pkg::*;

module sram_resp #(
  parameter int                ADDR_W = 32,
  parameter int                DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h8000_0000),
  parameter int                LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int              IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE} + (ADDR_W + 1)'(4 * DEPTH);

  rd_state_t         rd_state_reg, rd_state_next;
  wr_state_t         wr_state_reg, wr_state_next;
  logic [3:0]        rd_cnt_reg, wr_cnt_reg;
  logic [3:0]        rd_delay, wr_delay;
  logic [ADDR_W-1:0] araddr_reg, awaddr_reg;
  logic [31:0]       wdata_reg, rdata_reg;
  logic [3:0]        wstrb_reg;
  logic [1:0]        rresp_reg, bresp_reg;
  logic              aw_got_reg, w_got_reg;
  logic              ar_hs, aw_hs, w_hs, b_hs;
  logic              rd_fire, wr_fire, rd_ok, wr_ok;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [7:0]        rd_lane [4];
  logic [31:0]       rd_word;

`ifdef SRAM_RESP_RAND_DELAY_EN
  logic [7:0] lfsr;

  delay_lfsr #(.SEED(LFSR_SEED)) u_delay_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .q     (lfsr)
  );

  assign rd_delay = lfsr[3:0];
  assign wr_delay = lfsr[7:4];
`else
  assign rd_delay = 4'(LAT);
  assign wr_delay = 4'(LAT);
`endif

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < LIMIT);
  endfunction

  assign rd_ok   = in_range(araddr_reg);
  assign wr_ok   = in_range(awaddr_reg);
  assign rd_idx  = IDX_W'((araddr_reg - BASE) >> 2);
  assign wr_idx  = IDX_W'((awaddr_reg - BASE) >> 2);
  assign rd_fire = (rd_state_reg == R_WAIT) && (rd_cnt_reg == 4'd0);
  assign wr_fire = (wr_state_reg == W_WAIT) && (wr_cnt_reg == 4'd0);

  assign ar_hs   = arvalid && arready;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign b_hs    = bvalid && bready;
  assign awready = !aw_got_reg;
  assign wready  = !w_got_reg;
  assign rdata   = rdata_reg;
  assign rresp   = rresp_reg;
  assign bresp   = bresp_reg;

  // One array per byte lane so strobed writes never touch neighbouring lanes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_fire && wr_ok && wstrb_reg[gi]) begin
          mem[wr_idx] <= wdata_reg[8*gi +: 8];
        end
      end
      assign rd_lane[gi] = mem[rd_idx];
    end
  endgenerate

  assign rd_word = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};

  always_comb begin
    rd_state_next = rd_state_reg;
    arready       = 1'b0;
    rvalid        = 1'b0;
    case (rd_state_reg)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) rd_state_next = R_WAIT;
      end
      R_WAIT: if (rd_cnt_reg == 4'd0) rd_state_next = R_RESP;
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    bvalid        = 1'b0;
    case (wr_state_reg)
      W_IDLE: if ((aw_got_reg || aw_hs) && (w_got_reg || w_hs)) wr_state_next = W_WAIT;
      W_WAIT: if (wr_cnt_reg == 4'd0) wr_state_next = W_RESP;
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_reg <= R_IDLE;
      rd_cnt_reg   <= 4'd0;
      araddr_reg   <= '0;
      rdata_reg    <= 32'd0;
      rresp_reg    <= RESP_OKAY;
    end else begin
      rd_state_reg <= rd_state_next;
      if (ar_hs) begin
        araddr_reg <= araddr;
        rd_cnt_reg <= rd_delay;
      end else if (rd_state_reg == R_WAIT && rd_cnt_reg != 4'd0) begin
        rd_cnt_reg <= rd_cnt_reg - 4'd1;
      end
      if (rd_fire) begin
        rdata_reg <= rd_ok ? rd_word : 32'd0;
        rresp_reg <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_reg <= W_IDLE;
      wr_cnt_reg   <= 4'd0;
      awaddr_reg   <= '0;
      wdata_reg    <= 32'd0;
      wstrb_reg    <= 4'd0;
      aw_got_reg   <= 1'b0;
      w_got_reg    <= 1'b0;
      bresp_reg    <= RESP_OKAY;
    end else begin
      wr_state_reg <= wr_state_next;
      if (b_hs) begin
        aw_got_reg <= 1'b0;
        w_got_reg  <= 1'b0;
      end else begin
        if (aw_hs) aw_got_reg <= 1'b1;
        if (w_hs)  w_got_reg  <= 1'b1;
      end
      if (aw_hs) awaddr_reg <= awaddr;
      if (w_hs) begin
        wdata_reg <= wdata;
        wstrb_reg <= wstrb;
      end
      if (wr_state_reg == W_IDLE && wr_state_next == W_WAIT) begin
        wr_cnt_reg <= wr_delay;
      end else if (wr_state_reg == W_WAIT && wr_cnt_reg != 4'd0) begin
        wr_cnt_reg <= wr_cnt_reg - 4'd1;
      end
      if (wr_fire) bresp_reg <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_sram_resp.sv
// Scoreboard bench for sram_resp: randomized reads/writes against a word-level
// reference memory, plus directed ordering, range, back-pressure and reset cases.
`timescale 1ns/1ps
module tb_sram_resp;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WIN   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic [1:0]  rresp, bresp;

  sram_resp #(.ADDR_W(32), .DEPTH(DEPTH), .BASE(BASE), .LAT(LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endfunction

  typedef struct { logic [31:0] data; logic [1:0] resp; int t0; } rexp_t;
  typedef struct { logic [1:0] resp; int t0; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];

  // Reference memory: word index -> contents, only words the bench has written.
  logic [31:0] ref_mem [int];

  function automatic bit addr_ok(logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic void check_lat(string name, int lat);
`ifdef SRAM_RESP_RAND_DELAY_EN
    check(name, 32'(lat >= 1 && lat <= 16), 32'd1);
`else
    check(name, 32'(lat), 32'(LAT + 1));
`endif
  endfunction

  // Monitor: pops the scoreboard whenever a response handshake is about to happen.
  int          r_rise, b_rise, lat_min = 99, lat_max = -1;
  logic        rvalid_d = 1'b0, bvalid_d = 1'b0;
  logic [31:0] rdata_first;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      rvalid_d = 1'b0;
      bvalid_d = 1'b0;
    end else begin
      if (rvalid && !rvalid_d) begin
        r_rise      = cyc;
        rdata_first = rdata;
      end
      if (rvalid) begin
        check("arready_low_while_rvalid", 32'(arready), 32'd0);
        check("rdata_stable", rdata, rdata_first);
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          check("r_unexpected_count", 32'd1, 32'(rq.size()));
        end else begin
          rexp_t e;
          e = rq.pop_front();
          check("rdata", rdata, e.data);
          check("rresp", 32'(rresp), 32'(e.resp));
          check_lat("r_latency", r_rise - e.t0);
          if (r_rise - e.t0 < lat_min) lat_min = r_rise - e.t0;
          if (r_rise - e.t0 > lat_max) lat_max = r_rise - e.t0;
          $display("READ  @%0d data=0x%08h resp=%0d lat=%0d", cyc, rdata, rresp, r_rise - e.t0);
        end
      end
      if (bvalid && !bvalid_d) b_rise = cyc;
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          check("b_unexpected_count", 32'd1, 32'(bq.size()));
        end else begin
          bexp_t e;
          e = bq.pop_front();
          check("bresp", 32'(bresp), 32'(e.resp));
          check_lat("b_latency", b_rise - e.t0);
          $display("WRITE @%0d resp=%0d lat=%0d", cyc, bresp, b_rise - e.t0);
        end
      end
      rvalid_d = rvalid;
      bvalid_d = bvalid;
    end
  end

  task automatic ar_issue(input logic [31:0] a, output int t);
    int n = 0;
    araddr  = a;
    arvalid = 1'b1;
    while (!arready && n < 300) begin @(posedge clk); #1; n++; end
    if (!arready) check("arready_timeout", 32'(arready), 32'd1);
    @(posedge clk); #1;
    t       = cyc;
    arvalid = 1'b0;
  endtask

  task automatic aw_issue(input logic [31:0] a, output int t);
    int n = 0;
    awaddr  = a;
    awvalid = 1'b1;
    while (!awready && n < 300) begin @(posedge clk); #1; n++; end
    if (!awready) check("awready_timeout", 32'(awready), 32'd1);
    @(posedge clk); #1;
    t       = cyc;
    awvalid = 1'b0;
  endtask

  task automatic w_issue(input logic [31:0] d, input logic [3:0] s, output int t);
    int n = 0;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    while (!wready && n < 300) begin @(posedge clk); #1; n++; end
    if (!wready) check("wready_timeout", 32'(wready), 32'd1);
    @(posedge clk); #1;
    t      = cyc;
    wvalid = 1'b0;
    check("wready_drop_after_w", 32'(wready), 32'd0);
  endtask

  task automatic wait_r();
    int n = 0;
    while (rq.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (rq.size() != 0) begin
      check("r_response_timeout", 32'(rq.size()), 32'd0);
      rq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_b();
    int n = 0;
    while (bq.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (bq.size() != 0) begin
      check("b_response_timeout", 32'(bq.size()), 32'd0);
      bq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic rd_push(input logic [31:0] a);
    int    t;
    rexp_t e;
    ar_issue(a, t);
    e.t0   = t;
    e.resp = addr_ok(a) ? 2'b00 : 2'b10;
    e.data = addr_ok(a) ? ref_mem[widx(a)] : 32'd0;
    rq.push_back(e);
  endtask

  task automatic rd(input logic [31:0] a);
    rd_push(a);
    wait_r();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int wl, input int al);
    int    ta, tw;
    bexp_t e;
    fork
      begin repeat (wl) begin @(posedge clk); #1; end w_issue(d, s, tw); end
      begin repeat (al) begin @(posedge clk); #1; end aw_issue(a, ta); end
    join
    e.t0   = (ta > tw) ? ta : tw;
    e.resp = addr_ok(a) ? 2'b00 : 2'b10;
    bq.push_back(e);
    if (addr_ok(a)) ref_mem[widx(a)] = merge(ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'd0, d, s);
    wait_b();
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] oor [4];
    oor[0] = BASE - 32'd4;
    oor[1] = BASE + 32'(4 * DEPTH);
    oor[2] = 32'h0000_0000;
    oor[3] = 32'hFFFF_FFFC;
    if ($urandom_range(0, 9) == 0) return oor[$urandom_range(0, 3)];
    return BASE + 32'(4 * $urandom_range(0, WIN - 1)) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t, ta, tw;
    logic [31:0] a, old;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    araddr  = '0;   awaddr  = '0;   wdata  = '0; wstrb = '0;
    rready  = 1'b1; bready  = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready",  32'(wready),  32'd1);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
    check("rst_bresp",   32'(bresp),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < WIN; i++) wr(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0);

    wr(32'h8000_0010, 32'hDEADBEEF, 4'hF, 0, 0);
    rd(32'h8000_0010);

    wr(32'h8000_0014, 32'h1122_3344, 4'hF, 0, 0);
    wr(32'h8000_0014, 32'hAABB_CCDD, 4'b0101, 0, 0);
    rd(32'h8000_0014);
    wr(32'h8000_0018, 32'h0BAD_F00D, 4'h0, 0, 0);
    rd(32'h8000_0018);

    wr(32'h8000_001C, 32'hCAFE_0001, 4'hF, 0, 5);
    wr(32'h8000_0020, 32'hCAFE_0002, 4'hF, 4, 0);
    rd(32'h8000_001C);

    rd(32'h7FFF_FFFC);
    wr(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 0);
    rd(32'h8000_0000);
    rd(32'h8000_0FFC + 32'd4);

    rready = 1'b0;
    rd_push(32'h8000_0004);
    wr(32'h8000_0008, 32'h5A5A_A5A5, 4'hF, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("rvalid_held", 32'(rvalid), 32'd1);
    rready = 1'b1;
    wait_r();
    rd(32'h8000_0008);

`ifndef SRAM_RESP_RAND_DELAY_EN
    a   = 32'h8000_0024;
    old = ref_mem[widx(a)];
    fork
      aw_issue(a, ta);
      w_issue(~old, 4'hF, tw);
    join
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_bvalid",  32'(bvalid),  32'd0);
    check("midrst_awready", 32'(awready), 32'd1);
    check("midrst_wready",  32'(wready),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_bvalid_after_reset", 32'(bvalid), 32'd0);
    end
    @(posedge clk); #1;
    rd(a);
`endif

    for (int k = 0; k < 60; k++) begin
      int op;
      op = $urandom_range(0, 9);
      a  = pick_addr();
      if (op < 5) wr(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      else        rd(a);
    end

`ifdef SRAM_RESP_RAND_DELAY_EN
    lat_min = 99;
    lat_max = -1;
    for (int k = 0; k < 100; k++) rd(BASE + 32'(4 * $urandom_range(0, WIN - 1)));
    check("rand_delay_varies", 32'(lat_max > lat_min), 32'd1);
`endif

    repeat (5) @(posedge clk);
    check("rq_drained", 32'(rq.size()), 32'd0);
    check("bq_drained", 32'(bq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
